regfile_write_arbiter: RTL and testbench

Shares the single register-file write port among N_REQ requesters: round-robin arbitration, optional locked bursts, registered outputs. wr_sel drives the 3-to-8 write decoder's ctrl input, wr_enable drives its Enable input, and wr_data feeds the register inputs. The block sits between the execution/writeback sources and the register file.

---
 rtl/regfile_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port among N_REQ requesters.
// Round-robin arbitration with optional locked bursts; all write-port
// outputs are registered, so a transfer in cycle t appears on
// wr_enable/wr_sel/wr_data (or r0_drop) in cycle t+1.
//
// Handshake: a transfer from requester i happens in a cycle where
// req_valid[i] & req_ready[i]. req_ready is at most one-hot, is never high
// without the matching req_valid, and depends only on current state and
// req_valid. A requester keeps valid/addr/data/lock stable until its transfer.

module regfile_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 3,
  parameter int MAX_BURST  = 4,
  parameter int PROTECT_R0 = 1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     wr_enable,
  output logic [ADDR_W-1:0]        wr_sel,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     r0_drop,
  output logic [0:0]               dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_inc;

  logic [N_REQ-1:0]  grant_vec;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [IDX_W:0]    cand;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              grant_is_r0;
  logic              owner_valid;

  // Index of the requester after i, wrapping N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1)) return '0;
    else return i + IDX_W'(1);
  endfunction

  assign owner_valid   = req_valid[owner];
  assign burst_cnt_inc = burst_cnt + CNT_W'(1);
  assign dbg_state     = state;

  // Pick the granted requester: owner only while locked, otherwise the first
  // valid requester searching upward from rr_ptr with wrap-around.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (state == ST_LOCKED) begin
      if (owner_valid) begin
        grant_vec[owner] = 1'b1;
        grant_idx        = owner;
        grant_any        = 1'b1;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
        if (!grant_any && req_valid[cand[IDX_W-1:0]]) begin
          grant_vec[cand[IDX_W-1:0]] = 1'b1;
          grant_idx                  = cand[IDX_W-1:0];
          grant_any                  = 1'b1;
        end
      end
    end
  end

  // Holding reset keeps the grant low even though the state alone would
  // select requester 0.
  assign req_ready = ctrl_reset_n ? grant_vec : '0;

  assign grant_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign grant_data  = req_data[grant_idx*DATA_W +: DATA_W];
  assign grant_is_r0 = (PROTECT_R0 != 0) && (grant_addr == '0);

  // Arbitration state: round-robin pointer, lock owner and burst length.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant_any) begin
            if (req_lock[grant_idx] && (MAX_BURST > 1)) begin
              state     <= ST_LOCKED;
              owner     <= grant_idx;
              burst_cnt <= CNT_W'(1);
            end else begin
              rr_ptr <= next_idx(grant_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (!owner_valid) begin
            // Owner went idle: release without a grant this cycle.
            state     <= ST_ARB;
            rr_ptr    <= next_idx(owner);
            burst_cnt <= '0;
          end else if (!req_lock[owner] ||
                       (burst_cnt_inc == CNT_W'(MAX_BURST))) begin
            state     <= ST_ARB;
            rr_ptr    <= next_idx(owner);
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt_inc;
          end
        end
        default: begin
          state     <= ST_ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // Registered write port; a discarded register-0 write pulses r0_drop and
  // leaves wr_sel/wr_data untouched.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_enable <= 1'b0;
      wr_sel    <= '0;
      wr_data   <= '0;
      r0_drop   <= 1'b0;
    end else begin
      wr_enable <= grant_any && !grant_is_r0;
      r0_drop   <= grant_any && grant_is_r0;
      if (grant_any && !grant_is_r0) begin
        wr_sel  <= grant_addr;
        wr_data <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, compared every cycle against a reference model of the arbitration
// rules. Two instances run side by side, one with register-0 protection and
// one without.

module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MB = 4;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_lock;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;

  logic [N-1:0]      a_ready, b_ready;
  logic              a_en, b_en, a_drop, b_drop;
  logic [AW-1:0]     a_sel, b_sel;
  logic [DW-1:0]     a_data, b_data;
  logic [0:0]        a_dbg, b_dbg;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state
  bit            m_locked;
  int            m_owner, m_cnt, m_ptr;
  int            last_grant;
  logic          e_en_a, e_drop_a, e_en_b, e_drop_b;
  logic [AW-1:0] e_sel_a, e_sel_b;
  logic [DW-1:0] e_data_a, e_data_b;

  regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW),
                          .MAX_BURST(MB), .PROTECT_R0(1)) dut_a (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(a_ready), .wr_enable(a_en), .wr_sel(a_sel),
    .wr_data(a_data), .r0_drop(a_drop), .dbg_state(a_dbg)
  );

  regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW),
                          .MAX_BURST(MB), .PROTECT_R0(0)) dut_b (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(b_ready), .wr_enable(b_en), .wr_sel(b_sel),
    .wr_data(b_data), .r0_drop(b_drop), .dbg_state(b_dbg)
  );

  // clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; last_grant = -1;
    e_en_a = 0; e_drop_a = 0; e_sel_a = '0; e_data_a = '0;
    e_en_b = 0; e_drop_b = 0; e_sel_b = '0; e_data_b = '0;
  endtask

  // Who the rules say wins this cycle, or -1.
  function automatic int model_grant();
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    e_en_a = 0; e_drop_a = 0; e_en_b = 0; e_drop_b = 0;
    if (m_locked && !req_valid[m_owner]) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
    end else if (g >= 0) begin
      ad = req_addr[g*AW +: AW];
      da = req_data[g*DW +: DW];
      if (ad == 0) e_drop_a = 1;
      else begin e_en_a = 1; e_sel_a = ad; e_data_a = da; end
      e_en_b = 1; e_sel_b = ad; e_data_b = da;
      if (!m_locked) begin
        if (req_lock[g] && MB > 1) begin m_locked = 1; m_owner = g; m_cnt = 1; end
        else m_ptr = (g + 1) % N;
      end else begin
        m_cnt++;
        if (!req_lock[g] || m_cnt == MB) begin m_locked = 0; m_ptr = (g + 1) % N; m_cnt = 0; end
      end
    end
  endtask

  // Everything reads zero while reset is held.
  task automatic check_reset_outputs();
    chk("rst_ready_a", 64'(a_ready), 64'(0));
    chk("rst_ready_b", 64'(b_ready), 64'(0));
    chk("rst_en_a",    64'(a_en),    64'(0));
    chk("rst_sel_a",   64'(a_sel),   64'(0));
    chk("rst_data_a",  64'(a_data),  64'(0));
    chk("rst_drop_a",  64'(a_drop),  64'(0));
    chk("rst_state_a", 64'(a_dbg),   64'(0));
    chk("rst_en_b",    64'(b_en),    64'(0));
  endtask

  // One clock: check at the falling edge, advance the model, then drive at posedge+1.
  task automatic cycle(input bit use_want, input logic [N-1:0] want);
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clock);
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("ready_a", 64'(a_ready), 64'(exp_ready));
    chk("ready_b", 64'(b_ready), 64'(exp_ready));
    if (use_want) chk("dir_ready", 64'(a_ready), 64'(want));
    chk("state_a", 64'(a_dbg),  64'(m_locked));
    chk("en_a",    64'(a_en),   64'(e_en_a));
    chk("drop_a",  64'(a_drop), 64'(e_drop_a));
    chk("sel_a",   64'(a_sel),  64'(e_sel_a));
    chk("data_a",  64'(a_data), 64'(e_data_a));
    chk("en_b",    64'(b_en),   64'(e_en_b));
    chk("drop_b",  64'(b_drop), 64'(e_drop_b));
    chk("sel_b",   64'(b_sel),  64'(e_sel_b));
    chk("data_b",  64'(b_data), 64'(e_data_b));
    model_step(g);
    last_grant = g;
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    req_valid = '1; req_lock = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
    end
    model_reset();
    #12;
    check_reset_outputs();
    @(posedge clock); #1;
    ctrl_reset_n = 1'b1;

    // round-robin with all valid, addrs 1..4
    cycle(1, 4'b0001);
    cycle(1, 4'b0010);
    cycle(1, 4'b0100);
    cycle(1, 4'b1000);
    cycle(1, 4'b0001);
    req_valid = '0;
    cycle(1, 4'b0000);

    // burst cap: requester 2 locked, requester 1 waiting
    req_addr[2*AW +: AW] = 3'd5; req_data[2*DW +: DW] = 32'hA5A5_0002;
    req_valid = 4'b0100; req_lock = 4'b0100;
    cycle(1, 4'b0100);
    req_valid = 4'b0110;
    cycle(1, 4'b0100);
    cycle(1, 4'b0100);
    cycle(1, 4'b0100);
    cycle(1, 4'b0010);
    req_valid = '0; req_lock = '0;
    cycle(1, 4'b0000);

    // early unlock: requester 1 locks, second transfer clears lock
    req_valid = 4'b0010; req_lock = 4'b0010;
    cycle(1, 4'b0010);
    req_valid = 4'b0111; req_lock = 4'b0000;
    cycle(1, 4'b0010);
    req_valid = 4'b0101;
    cycle(1, 4'b0100);
    req_valid = '0;
    cycle(1, 4'b0000);

    // owner drop: requester 3 locked, then goes idle
    req_valid = 4'b1000; req_lock = 4'b1000;
    cycle(1, 4'b1000);
    cycle(1, 4'b1000);
    req_valid = 4'b0001; req_lock = 4'b0000;
    cycle(1, 4'b0000);
    cycle(1, 4'b0001);
    req_valid = '0;
    cycle(1, 4'b0000);

    // register-0 write: dropped by instance a, written by instance b
    req_addr[0 +: AW] = '0; req_data[0 +: DW] = 32'hDEAD_BEEF;
    req_valid = 4'b0001;
    cycle(1, 4'b0001);
    req_valid = '0;
    cycle(1, 4'b0000);
    chk("r0_drop_pulse", 64'(a_drop), 64'(0));

    // reset in the middle of a burst releases the lock
    req_valid = 4'b0100; req_lock = 4'b0100;
    cycle(1, 4'b0100);
    ctrl_reset_n = 1'b0;
    #2;
    check_reset_outputs();
    model_reset();
    #1;
    ctrl_reset_n = 1'b1;
    req_valid = 4'b0010; req_lock = '0;
    cycle(1, 4'b0010);
    req_valid = '0;
    cycle(1, 4'b0000);

    // random traffic; requests hold until transferred
    for (int c = 0; c < 3000; c++) begin
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
          req_data[i*DW +: DW] = $urandom;
          req_lock[i] = ($urandom_range(0, 2) == 0);
        end
      end
      if (m_locked && req_valid[m_owner] && $urandom_range(0, 9) == 0)
        req_valid[m_owner] = 1'b0;
      cycle(0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
